// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// fir_pkg : shared constants and lane-phase type for the unfolded FIR output
// Revision : 1.0
// ============================================================================
package fir_pkg;

    localparam int NBIT_DEF = 8;
    localparam int LANES    = 3;

    typedef enum logic [1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2
    } lane_t;

endpackage
`default_nettype wire

// File: rtl/word_fifo.sv
`default_nettype none
// ============================================================================
// word_fifo : generic synchronous FIFO, head word readable without a pop
// Revision  : 1.0
// ============================================================================
module word_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer wrap is plain overflow.
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/fir_unfold_serializer.sv
`default_nettype none
// ============================================================================
// fir_unfold_serializer : 3-sample words in, one sample per handshake out
// Revision : 1.0
// ============================================================================
module fir_unfold_serializer
    import fir_pkg::*;
#(
    parameter int NBIT  = NBIT_DEF,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBIT-1:0] din3k,
    input  logic [NBIT-1:0] din3k1,
    input  logic [NBIT-1:0] din3k2,
    input  logic            vin,
    input  logic            ready,
    output logic [NBIT-1:0] dout,
    output logic            vout,
    output logic            full,
    output logic            empty,
    output logic            ovf
);

    localparam int WIDTH = LANES * NBIT;

    lane_t            phase_q, phase_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] head;
    logic             xfer, pop, push, drop;

    assign xfer = !empty && ready;
    assign pop  = xfer && (phase_q == LANE2);
    assign push = vin && (!full || pop);
    assign drop = vin && full && !pop;

    word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({din3k2, din3k1, din3k}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        phase_d = phase_q;
        ovf_d   = ovf_q || drop;
        if (xfer) begin
            case (phase_q)
                LANE0:   phase_d = LANE1;
                LANE1:   phase_d = LANE2;
                default: phase_d = LANE0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= LANE0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ovf_q   <= ovf_d;
        end
    end

    // Output mux sees only FIFO state and the phase flop, never the inputs.
    always_comb begin
        dout = '0;
        if (!empty) begin
            case (phase_q)
                LANE0:   dout = head[0*NBIT +: NBIT];
                LANE1:   dout = head[1*NBIT +: NBIT];
                default: dout = head[2*NBIT +: NBIT];
            endcase
        end
    end

    assign vout = !empty;
    assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_unfold_serializer.sv
`default_nettype none
// ============================================================================
// tb_fir_unfold_serializer : scoreboard bench for the output serializer
// Revision : 1.0
// ============================================================================
module tb_fir_unfold_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din3k = '0, din3k1 = '0, din3k2 = '0;
    logic       vin = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] dout;
    logic       vout, full, empty, ovf;

    logic [7:0] q[$];
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         sample_cnt = 0;

    fir_unfold_serializer #(.NBIT(8), .DEPTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .din3k  (din3k),
        .din3k1 (din3k1),
        .din3k2 (din3k2),
        .vin    (vin),
        .ready  (ready),
        .dout   (dout),
        .vout   (vout),
        .full   (full),
        .empty  (empty),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // Scoreboard: every sample handed over on the next edge is checked in order.
    always @(negedge clk) begin
        if (rst_n && vout === 1'b1 && ready === 1'b1) begin
            logic [7:0] exp_s;
            total_cnt++;
            sample_cnt++;
            if (q.size() == 0) begin
                $display("FAIL scoreboard_extra: dout=%0d emitted with nothing expected", dout);
            end else begin
                exp_s = q.pop_front();
                if (dout !== exp_s)
                    $display("FAIL scoreboard_order: dout=%0d expected %0d", dout, exp_s);
                else
                    pass_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        vin   = 1'b0;
        ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        q.delete();
    endtask

    task automatic push_word(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        @(posedge clk);
        #1;
        din3k = a; din3k1 = b; din3k2 = c; vin = 1'b1;
        q.push_back(a); q.push_back(b); q.push_back(c);
        @(posedge clk);
        #1 vin = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        ready = 1'b0;
        push_word(8'd55, 8'd66, 8'd77);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total_cnt++; if (dout !== 8'd0)  $display("FAIL reset_dout: got %0d want 0", dout);  else pass_cnt++;
        total_cnt++; if (vout !== 1'b0)  $display("FAIL reset_vout: got %b want 0", vout);   else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else pass_cnt++;
        total_cnt++; if (full !== 1'b0)  $display("FAIL reset_full: got %b want 0", full);   else pass_cnt++;
        total_cnt++; if (ovf !== 1'b0)   $display("FAIL reset_ovf: got %b want 0", ovf);     else pass_cnt++;
        q.delete();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_single_word();
        ready = 1'b1;
        push_word(8'd10, 8'd20, 8'd30);
        @(negedge clk);
        total_cnt++;
        if (vout !== 1'b1 || dout !== 8'd10)
            $display("FAIL single_latency: vout=%b dout=%0d want vout=1 dout=10", vout, dout);
        else pass_cnt++;
        for (int i = 0; i < 40 && !(q.size() == 0 && empty === 1'b1); i++) @(negedge clk);
        total_cnt++;
        if (q.size() != 0 || empty !== 1'b1)
            $display("FAIL single_drain: pending=%0d empty=%b want 0/1", q.size(), empty);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (vout !== 1'b0 || dout !== 8'd0)
            $display("FAIL single_idle: vout=%b dout=%0d want 0/0", vout, dout);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        ready = 1'b1;
        push_word(8'd1, 8'd2, 8'd3);
        @(posedge clk);
        #1 ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total_cnt++;
            if (dout !== 8'd2 || vout !== 1'b1)
                $display("FAIL bp_hold: cycle %0d dout=%0d vout=%b want 2/1", i, dout, vout);
            else pass_cnt++;
        end
        ready = 1'b1;
        for (int i = 0; i < 40 && !(q.size() == 0 && empty === 1'b1); i++) @(negedge clk);
        total_cnt++;
        if (q.size() != 0 || empty !== 1'b1)
            $display("FAIL bp_drain: pending=%0d empty=%b want 0/1", q.size(), empty);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        int start_cnt;
        apply_reset();
        ready = 1'b0;
        @(posedge clk);
        #1;
        for (int w = 0; w < 5; w++) begin
            din3k  = 8'(100 + 3 * w);
            din3k1 = 8'(101 + 3 * w);
            din3k2 = 8'(102 + 3 * w);
            vin    = 1'b1;
            if (w < 4) begin
                q.push_back(din3k); q.push_back(din3k1); q.push_back(din3k2);
            end
            @(posedge clk);
            #1;
            if (w == 3) begin
                total_cnt++;
                if (full !== 1'b1 || ovf !== 1'b0)
                    $display("FAIL ovf_full4: full=%b ovf=%b want 1/0", full, ovf);
                else pass_cnt++;
            end
            if (w == 4) begin
                total_cnt++;
                if (full !== 1'b1 || ovf !== 1'b1)
                    $display("FAIL ovf_set5: full=%b ovf=%b want 1/1", full, ovf);
                else pass_cnt++;
            end
        end
        vin = 1'b0;
        start_cnt = sample_cnt;
        ready = 1'b1;
        for (int i = 0; i < 60 && !(q.size() == 0 && empty === 1'b1); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (sample_cnt - start_cnt != 12 || q.size() != 0)
            $display("FAIL ovf_count: emitted=%0d want 12 (pending=%0d)", sample_cnt - start_cnt, q.size());
        else pass_cnt++;
        total_cnt++;
        if (ovf !== 1'b1) $display("FAIL ovf_sticky: ovf=%b want 1", ovf); else pass_cnt++;
    endtask

    task automatic test_full_pop();
        int start_cnt;
        apply_reset();
        total_cnt++;
        if (ovf !== 1'b0) $display("FAIL fp_ovf_cleared: ovf=%b want 0", ovf); else pass_cnt++;
        start_cnt = sample_cnt;
        ready = 1'b0;
        @(posedge clk);
        #1;
        for (int w = 0; w < 4; w++) begin
            din3k  = 8'(150 + 3 * w);
            din3k1 = 8'(151 + 3 * w);
            din3k2 = 8'(152 + 3 * w);
            vin    = 1'b1;
            q.push_back(din3k); q.push_back(din3k1); q.push_back(din3k2);
            @(posedge clk);
            #1;
        end
        vin   = 1'b0;
        ready = 1'b1;
        total_cnt++;
        if (full !== 1'b1) $display("FAIL fp_full: full=%b want 1", full); else pass_cnt++;
        @(posedge clk);
        @(posedge clk);
        #1;
        din3k = 8'd201; din3k1 = 8'd202; din3k2 = 8'd203; vin = 1'b1;
        q.push_back(8'd201); q.push_back(8'd202); q.push_back(8'd203);
        @(posedge clk);
        #1 vin = 1'b0;
        total_cnt++;
        if (full !== 1'b1 || ovf !== 1'b0)
            $display("FAIL fp_accept: full=%b ovf=%b want 1/0", full, ovf);
        else pass_cnt++;
        for (int i = 0; i < 60 && !(q.size() == 0 && empty === 1'b1); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (sample_cnt - start_cnt != 15 || ovf !== 1'b0)
            $display("FAIL fp_drain: emitted=%0d ovf=%b want 15/0", sample_cnt - start_cnt, ovf);
        else pass_cnt++;
    endtask

    task automatic test_midword_reset();
        apply_reset();
        ready = 1'b1;
        push_word(8'd4, 8'd5, 8'd6);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (vout !== 1'b0 || dout !== 8'd0 || empty !== 1'b1)
            $display("FAIL mid_reset: vout=%b dout=%0d empty=%b want 0/0/1", vout, dout, empty);
        else pass_cnt++;
        q.delete();
        #4 rst_n = 1'b1;
        push_word(8'd7, 8'd8, 8'd9);
        @(negedge clk);
        total_cnt++;
        if (dout !== 8'd7 || vout !== 1'b1)
            $display("FAIL mid_restart: dout=%0d vout=%b want 7/1", dout, vout);
        else pass_cnt++;
        for (int i = 0; i < 40 && !(q.size() == 0 && empty === 1'b1); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        total_cnt++;
        if (q.size() != 0 || empty !== 1'b1)
            $display("FAIL mid_drain: pending=%0d empty=%b want 0/1", q.size(), empty);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_midword_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
